// File: rtl/bean_pkg.sv
// Shared widths and the queue entry layout for the fetch/issue path.
package bean_pkg;
    localparam int XPR_LEN     = 32;
    localparam int FETCH_WIDTH = 4;
    localparam int INST_BYTES  = 4;
    localparam int QDEPTH      = 8;
    localparam int PTR_W       = $clog2(QDEPTH);

    typedef struct packed {
        logic [XPR_LEN-1:0] inst;
        logic [XPR_LEN-1:0] pc;
    } iq_entry_t;
endpackage

// File: rtl/fetch_slot_ram.sv
// Queue storage: one write port per fetch lane, single asynchronous read at head.
module fetch_slot_ram
    import bean_pkg::*;
(
    input  logic                                clk,
    input  logic [FETCH_WIDTH-1:0]              wr_en,
    input  logic [FETCH_WIDTH-1:0][PTR_W-1:0]   wr_addr,
    input  iq_entry_t [FETCH_WIDTH-1:0]         wr_data,
    input  logic [PTR_W-1:0]                    rd_addr,
    output iq_entry_t                           rd_data
);
    iq_entry_t mem [QDEPTH];

    // Lanes of one packet always target distinct slots, so no port conflicts.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_issue_queue.sv
// Circular buffer between fetch and decode: packet-wide push, one-instruction pop.
module fetch_issue_queue
    import bean_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_valid,
    output logic                           fetch_ready,
    input  logic [FETCH_WIDTH*XPR_LEN-1:0] fetch_data,
    input  logic [XPR_LEN-1:0]             fetch_pc,
    input  logic [1:0]                     fetch_offset,
    input  logic                           drop,
    output logic                           dec_valid,
    input  logic                           dec_ready,
    output logic [XPR_LEN-1:0]             dec_inst,
    output logic [XPR_LEN-1:0]             dec_pc,
    output logic [PTR_W:0]                 count
);
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(QDEPTH - FETCH_WIDTH);

    logic [PTR_W-1:0]                  head;
    logic [PTR_W-1:0]                  tail;
    logic [PTR_W-1:0]                  push_n;
    logic                              push;
    logic                              pop;
    logic [FETCH_WIDTH-1:0]            wr_en;
    logic [FETCH_WIDTH-1:0][PTR_W-1:0] wr_addr;
    iq_entry_t [FETCH_WIDTH-1:0]       wr_data;
    logic [1:0]                        word_idx [FETCH_WIDTH];
    iq_entry_t                         head_entry;

    // Ready looks only at the registered count, so a same-cycle pop never makes room.
    assign fetch_ready = !rst && !drop && (count <= READY_MAX);
    assign push        = fetch_valid && fetch_ready;
    assign push_n      = PTR_W'(FETCH_WIDTH) - {1'b0, fetch_offset};
    assign dec_valid   = (count != '0);
    assign pop         = dec_valid && dec_ready;

    // Lane k carries packet word offset+k; its PC is rebuilt from the aligned base.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            word_idx[k]     = fetch_offset + 2'(k);
            wr_en[k]        = push && (PTR_W'(k) < push_n);
            wr_addr[k]      = tail + PTR_W'(k);
            wr_data[k].inst = fetch_data[XPR_LEN*word_idx[k] +: XPR_LEN];
            wr_data[k].pc   = {fetch_pc[XPR_LEN-1:4], word_idx[k], 2'b00};
        end
    end

    fetch_slot_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (head),
        .rd_data (head_entry)
    );

    assign dec_inst = dec_valid ? head_entry.inst : '0;
    assign dec_pc   = dec_valid ? head_entry.pc   : '0;

    always_ff @(posedge clk) begin
        if (rst || drop) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + (push ? push_n : '0);
            count <= count + (push ? {1'b0, push_n} : '0) - (PTR_W+1)'(pop);
        end
    end

    // The 2-bit offset port cannot exceed the packet, so only alignment needs checking.
    always @(posedge clk) begin
        if (!rst && push) begin
            assert (fetch_pc[3:0] == 4'h0)
                else $error("fetch_pc %h not 16-byte aligned", fetch_pc);
        end
    end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Table-driven bench for fetch_issue_queue with a queue scoreboard of issued entries.
module tb_fetch_issue_queue;
    import bean_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           fetch_valid = 1'b0;
    logic                           fetch_ready;
    logic [FETCH_WIDTH*XPR_LEN-1:0] fetch_data = '0;
    logic [XPR_LEN-1:0]             fetch_pc = '0;
    logic [1:0]                     fetch_offset = '0;
    logic                           drop = 1'b0;
    logic                           dec_valid;
    logic                           dec_ready = 1'b0;
    logic [XPR_LEN-1:0]             dec_inst;
    logic [XPR_LEN-1:0]             dec_pc;
    logic [PTR_W:0]                 count;

    typedef struct {
        logic        v;
        logic [31:0] tag;
        logic [31:0] pc;
        logic [1:0]  off;
        logic        drp;
        logic        rdy;
        int          cnt;
    } vec_t;

    vec_t      vecs[$];
    iq_entry_t sb[$];
    int        n_vec  = 0;
    int        n_fail = 0;

    fetch_issue_queue dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_data   (fetch_data),
        .fetch_pc     (fetch_pc),
        .fetch_offset (fetch_offset),
        .drop         (drop),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_inst     (dec_inst),
        .dec_pc       (dec_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pkt(input logic [31:0] tag);
        logic [127:0] p;
        for (int i = 0; i < 4; i++) p[32*i +: 32] = tag + 32'(i);
        return p;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] tag, input logic [31:0] pc,
                                 input logic [1:0] off, input logic drp, input logic rdy,
                                 input int cnt);
        vec_t r;
        r.v = v; r.tag = tag; r.pc = pc; r.off = off; r.drp = drp; r.rdy = rdy; r.cnt = cnt;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against the model, update model, check count after edge.
    task automatic applyStimulus(input logic v, input logic [31:0] tag, input logic [31:0] pc,
                                 input logic [1:0] off, input logic drp, input logic rdy,
                                 input logic r, input int cnt);
        logic exp_ready;
        fetch_valid  = v;
        fetch_data   = pkt(tag);
        fetch_pc     = pc;
        fetch_offset = off;
        drop         = drp;
        dec_ready    = rdy;
        rst          = r;
        #1;
        exp_ready = !r && !drp && (sb.size() <= QDEPTH - FETCH_WIDTH);
        checkOutput("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
        if (!r) begin
            checkOutput("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                checkOutput("dec_inst", dec_inst, sb[0].inst);
                checkOutput("dec_pc", dec_pc, sb[0].pc);
            end else begin
                checkOutput("dec_inst_idle", dec_inst, 32'h0);
                checkOutput("dec_pc_idle", dec_pc, 32'h0);
            end
        end
        if (r || drp) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && rdy) void'(sb.pop_front());
            if (v && exp_ready) begin
                for (int i = int'(off); i < FETCH_WIDTH; i++) begin
                    iq_entry_t e;
                    e.inst = tag + 32'(i);
                    e.pc   = pc + 32'(4 * i);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("count", 32'(count), 32'(cnt));
        if (r || drp) checkOutput("dec_valid_flushed", 32'(dec_valid), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        // aligned push, then four consecutive issues
        vecs.push_back(mkv(1, 32'hA000_0000, 32'h100, 0, 0, 1, 4));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0));
        // mid-line entry trims words 0 and 1
        vecs.push_back(mkv(1, 32'hB000_0000, 32'h200, 2, 0, 0, 2));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0));
        // fill to full, third packet held until four pops free a packet's worth
        vecs.push_back(mkv(1, 32'hC000_0000, 32'h300, 0, 0, 0, 4));
        vecs.push_back(mkv(1, 32'hC100_0000, 32'h310, 0, 0, 0, 8));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 0, 8));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 1, 7));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 1, 6));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 1, 5));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 1, 4));
        vecs.push_back(mkv(1, 32'hC200_0000, 32'h320, 0, 0, 1, 7));
        for (int i = 6; i >= 0; i--) vecs.push_back(mkv(0, 0, 0, 0, 0, 1, i));
        // simultaneous push and pop from count 3
        vecs.push_back(mkv(1, 32'hD000_0000, 32'h400, 1, 0, 0, 3));
        vecs.push_back(mkv(1, 32'hD100_0000, 32'h410, 0, 0, 1, 6));
        for (int i = 5; i >= 0; i--) vecs.push_back(mkv(0, 0, 0, 0, 0, 1, i));
        // drop with count 5 and a concurrent push
        vecs.push_back(mkv(1, 32'hE000_0000, 32'h500, 0, 0, 0, 4));
        vecs.push_back(mkv(1, 32'hE100_0000, 32'h510, 3, 0, 0, 5));
        vecs.push_back(mkv(1, 32'hE200_0000, 32'h520, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 32'hF000_0000, 32'h600, 0, 0, 1, 4));
        for (int i = 3; i >= 0; i--) vecs.push_back(mkv(0, 0, 0, 0, 0, 1, i));

        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].tag, vecs[i].pc, vecs[i].off,
                          vecs[i].drp, vecs[i].rdy, 1'b0, vecs[i].cnt);
        end

        // reset mid-operation overrides a concurrent push and leaves no residue
        applyStimulus(1, 32'h7000_0000, 32'h700, 0, 0, 0, 0, 4);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 3);
        applyStimulus(1, 32'h7100_0000, 32'h710, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 32'h7200_0000, 32'h720, 1, 0, 1, 0, 3);
        for (int i = 2; i >= 0; i--) applyStimulus(0, 0, 0, 0, 0, 1, 0, i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
